// File: rtl/fetch_bus_responder.sv
// Fetch instruction-bus responder: word-organised memory returning one fetch group per request.
// Optional random stalls are compiled in with `define IBUS_RANDOM_STALL_EN.
//
// state  | meaning
// IDLE   | nothing outstanding; samples req/addr at every edge
// WAIT   | request captured; latency down-counter running, or stalling at terminal count
// ACK    | response cycle; ack and data valid for exactly this cycle
module fetch_bus_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int FETCH_WIDTH = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY = 1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [ADDR_WIDTH-1:0]                      fetch_bus_addr,
  input  logic                                       fetch_bus_read_req,
  output logic [INSTRUCTION_WIDTH*FETCH_WIDTH-1:0]   bus_fetch_data,
  output logic                                       bus_fetch_read_ack,
  input  logic                                       prog_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0]             prog_addr,
  input  logic [INSTRUCTION_WIDTH-1:0]               prog_data
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int DATA_W = INSTRUCTION_WIDTH * FETCH_WIDTH;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   cap_q, cap_d;
  logic                    load_data;
  logic                    restart;
  logic                    stall_taken;
  logic                    stall_now;
  logic                    ack_q;
  logic [DATA_W-1:0]       data_q;
  logic [IDX_W-1:0]        rd_idx;
  logic [INSTRUCTION_WIDTH-1:0] mem [DEPTH_WORDS];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cap_d       = cap_q;
    load_data   = 1'b0;
    restart     = 1'b0;
    stall_taken = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fetch_bus_read_req) begin
          cap_d   = fetch_bus_addr;
          cnt_d   = LAT_M1;
          restart = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!fetch_bus_read_req) begin
          state_d = S_IDLE;
        end else if (fetch_bus_addr != cap_q) begin
          cap_d   = fetch_bus_addr;
          cnt_d   = LAT_M1;
          restart = 1'b1;
        end else if (cnt_q > 4'd1) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          cnt_d = 4'd0;
        end
      end
      S_ACK: begin
        // fetch's reaction to this ack is not visible yet, so req is ignored here
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Terminal count: respond now unless the stall source holds the response back.
    if (state_d == S_WAIT && cnt_d == 4'd0) begin
      if (stall_now) begin
        stall_taken = 1'b1;
      end else begin
        state_d   = S_ACK;
        load_data = 1'b1;
      end
    end
  end

  assign rd_idx = IDX_W'((cap_d - BASE_ADDR) >> 2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
      ack_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      ack_q   <= load_data;
      if (load_data) begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
          data_q[i*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH] <= mem[rd_idx + IDX_W'(i)];
        end
      end
    end
  end

  // Same-edge writes are not seen by a response loaded at that edge.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

`ifdef IBUS_RANDOM_STALL_EN
  logic [15:0] lfsr_q;
  logic [1:0]  stall_cnt_q;

  assign stall_now = lfsr_q[0] && (stall_cnt_q != 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q      <= 16'hACE1;
      stall_cnt_q <= '0;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      if (restart) begin
        stall_cnt_q <= stall_taken ? 2'd1 : 2'd0;
      end else if (stall_taken) begin
        stall_cnt_q <= stall_cnt_q + 2'd1;
      end
    end
  end
`else
  logic unused_stall;
  assign stall_now    = 1'b0;
  assign unused_stall = restart | stall_taken;
`endif

  assign bus_fetch_read_ack = ack_q;
  assign bus_fetch_data     = data_q;

endmodule

// File: tb/tb_fetch_bus_responder.sv
// Bench for fetch_bus_responder: four latency variants share one stimulus stream and are
// checked against a deadline-based reference model plus directed scenario constants.
module tb_fetch_bus_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int DEPTH = 4096;
  localparam int IW = 32;
  localparam int FW = 4;
  localparam int DW = IW * FW;
  localparam int NI = 4;

  logic          clk;
  logic          rst;
  logic [31:0]   addr;
  logic          req;
  logic          prog_we;
  logic [11:0]   prog_addr;
  logic [31:0]   prog_data;
  logic [DW-1:0] dout [NI];
  logic          ack [NI];

  int n_cmp;
  int n_bad;
  int cyc;

  // reference model state
  logic [31:0]   mem_m [DEPTH];
  logic          m_busy [NI];
  logic          m_ack [NI];
  logic [31:0]   m_cap [NI];
  int            m_due [NI];
  logic [DW-1:0] m_data [NI];

  fetch_bus_responder #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .fetch_bus_addr(addr), .fetch_bus_read_req(req),
    .bus_fetch_data(dout[0]), .bus_fetch_read_ack(ack[0]),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data));
  fetch_bus_responder #(.LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .fetch_bus_addr(addr), .fetch_bus_read_req(req),
    .bus_fetch_data(dout[1]), .bus_fetch_read_ack(ack[1]),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data));
  fetch_bus_responder #(.LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst), .fetch_bus_addr(addr), .fetch_bus_read_req(req),
    .bus_fetch_data(dout[2]), .bus_fetch_read_ack(ack[2]),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data));
  fetch_bus_responder #(.LATENCY(5)) u_l5 (
    .clk(clk), .rst(rst), .fetch_bus_addr(addr), .fetch_bus_read_req(req),
    .bus_fetch_data(dout[3]), .bus_fetch_read_ack(ack[3]),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic int lat_of(input int k);
    case (k)
      0: return 1;
      1: return 3;
      2: return 4;
      default: return 5;
    endcase
  endfunction

  function automatic logic [DW-1:0] group_of(input logic [31:0] a);
    logic [DW-1:0] g;
    int first;
    first = int'((a - BASE) >> 2) % DEPTH;
    for (int i = 0; i < FW; i++) g[i*IW +: IW] = mem_m[(first + i) % DEPTH];
    return g;
  endfunction

  // One clock: the model consumes the inputs seen at the edge, outputs are sampled at negedge.
  // A request is answered at the edge (sample + LATENCY - 1); a redirect counts as a new sample.
  task automatic step();
    @(posedge clk);
    cyc++;
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        m_busy[k] = 1'b0;
        m_ack[k]  = 1'b0;
        m_data[k] = '0;
      end else if (m_ack[k]) begin
        m_ack[k] = 1'b0;
      end else begin
        if (m_busy[k] && !req) begin
          m_busy[k] = 1'b0;
        end else if (req && (!m_busy[k] || addr != m_cap[k])) begin
          m_busy[k] = 1'b1;
          m_cap[k]  = addr;
          m_due[k]  = cyc + lat_of(k) - 1;
        end
        if (m_busy[k] && m_due[k] == cyc) begin
          m_busy[k] = 1'b0;
          m_ack[k]  = 1'b1;
          m_data[k] = group_of(m_cap[k]);
        end
      end
    end
    if (prog_we) mem_m[prog_addr] = prog_data;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) step();
  endtask

  task automatic wr(input int i, input logic [31:0] v);
    prog_we   = 1'b1;
    prog_addr = 12'(i);
    prog_data = v;
    step();
    prog_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 1'b0;
    addr = BASE;
    prog_we = 1'b0;
    step();
    step();
    for (int k = 0; k < NI; k++) begin
      n_cmp++;
      if (ack[k] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_ack inst%0d: got %0b want 0", k, ack[k]);
      end
      n_cmp++;
      if (dout[k] !== {DW{1'b0}}) begin
        n_bad++;
        $display("FAIL reset_data inst%0d: got %h want 0", k, dout[k]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_load();
    for (int i = 0; i < DEPTH; i++) wr(i, $urandom);
  endtask

  task automatic test_basic();
    wr(0, 32'd1); wr(1, 32'd2); wr(2, 32'd3); wr(3, 32'd4);
    addr = BASE;
    req = 1'b1;
    step();
    n_cmp++;
    if (ack[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_ack: got %0b want 1", ack[0]);
    end
    n_cmp++;
    if (dout[0] !== {32'd4, 32'd3, 32'd2, 32'd1}) begin
      n_bad++;
      $display("FAIL basic_data: got %h want lanes 1,2,3,4", dout[0]);
    end
    req = 1'b0;
    step();
    n_cmp++;
    if (ack[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_ack_pulse: got %0b want 0", ack[0]);
    end
    idle(6);
  endtask

  task automatic test_wrap();
    wr(4095, 32'hAA); wr(0, 32'h10); wr(1, 32'h11); wr(2, 32'h12);
    addr = BASE + 32'h3FFC;
    req = 1'b1;
    step();
    n_cmp++;
    if (ack[0] !== 1'b1 || dout[0] !== {32'h12, 32'h11, 32'h10, 32'hAA}) begin
      n_bad++;
      $display("FAIL wrap: ack %0b data %h want ack 1 lanes AA,10,11,12", ack[0], dout[0]);
    end
    idle(6);
  endtask

  task automatic test_abort();
    int lat;
    logic got;
    logic stray;
    addr = BASE;
    req = 1'b1;
    step();
    step();
    req = 1'b0;
    stray = 1'b0;
    repeat (2) begin
      step();
      if (ack[2] !== 1'b0) stray = 1'b1;
    end
    n_cmp++;
    if (stray !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_no_ack: got ack after withdraw, want none");
    end
    addr = BASE + 32'h10;
    req = 1'b1;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 12) begin
      step();
      lat++;
      if (ack[2] === 1'b1) got = 1'b1;
    end
    req = 1'b0;
    n_cmp++;
    if (!got || lat != 4) begin
      n_bad++;
      $display("FAIL abort_relat: got ack=%0b after %0d edges, want ack after 4", got, lat);
    end
    n_cmp++;
    if (dout[2] !== {mem_m[7], mem_m[6], mem_m[5], mem_m[4]}) begin
      n_bad++;
      $display("FAIL abort_redata: got %h want %h", dout[2], {mem_m[7], mem_m[6], mem_m[5], mem_m[4]});
    end
    idle(8);
  endtask

  task automatic test_redirect();
    int acks;
    int lat;
    logic got;
    acks = 0;
    addr = BASE + 32'h40;
    req = 1'b1;
    step();
    if (ack[1] === 1'b1) acks++;
    step();
    if (ack[1] === 1'b1) acks++;
    addr = BASE + 32'h80;
    step();
    if (ack[1] === 1'b1) acks++;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 10) begin
      step();
      lat++;
      if (ack[1] === 1'b1) begin
        got = 1'b1;
        acks++;
      end
    end
    req = 1'b0;
    n_cmp++;
    if (!got || lat != 2) begin
      n_bad++;
      $display("FAIL redirect_lat: got ack=%0b %0d edges after redirect+1, want 2", got, lat);
    end
    n_cmp++;
    if (dout[1] !== {mem_m[35], mem_m[34], mem_m[33], mem_m[32]}) begin
      n_bad++;
      $display("FAIL redirect_data: got %h want %h", dout[1], {mem_m[35], mem_m[34], mem_m[33], mem_m[32]});
    end
    repeat (6) begin
      step();
      if (ack[1] === 1'b1) acks++;
    end
    n_cmp++;
    if (acks != 1) begin
      n_bad++;
      $display("FAIL redirect_single: got %0d acks want 1", acks);
    end
  endtask

  task automatic test_same_edge();
    addr = BASE;
    req = 1'b1;
    prog_we = 1'b1;
    prog_addr = 12'd0;
    prog_data = 32'h55;
    step();
    prog_we = 1'b0;
    n_cmp++;
    if (ack[0] !== 1'b1 || dout[0][31:0] !== 32'h10) begin
      n_bad++;
      $display("FAIL same_edge_old: ack %0b lane0 %h want ack 1 lane0 10", ack[0], dout[0][31:0]);
    end
    step();
    n_cmp++;
    if (ack[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL same_edge_gap: got ack %0b want 0", ack[0]);
    end
    step();
    n_cmp++;
    if (ack[0] !== 1'b1 || dout[0][31:0] !== 32'h55) begin
      n_bad++;
      $display("FAIL same_edge_new: ack %0b lane0 %h want ack 1 lane0 55", ack[0], dout[0][31:0]);
    end
    idle(8);
  endtask

  task automatic test_reset_mid();
    int lat;
    logic got;
    logic stray;
    addr = BASE + 32'h20;
    req = 1'b1;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 12) begin
      step();
      lat++;
      if (ack[3] === 1'b1) got = 1'b1;
    end
    req = 1'b0;
    n_cmp++;
    if (!got || lat != 5 || dout[3] !== {mem_m[11], mem_m[10], mem_m[9], mem_m[8]}) begin
      n_bad++;
      $display("FAIL lat5_txn: ack=%0b edges %0d data %h want ack after 5 data %h",
               got, lat, dout[3], {mem_m[11], mem_m[10], mem_m[9], mem_m[8]});
    end
    idle(2);
    addr = BASE + 32'h30;
    req = 1'b1;
    step();
    step();
    rst = 1'b1;
    req = 1'b0;
    step();
    rst = 1'b0;
    for (int k = 0; k < NI; k++) begin
      n_cmp++;
      if (ack[k] !== 1'b0 || dout[k] !== {DW{1'b0}}) begin
        n_bad++;
        $display("FAIL reset_mid inst%0d: ack %0b data %h want 0/0", k, ack[k], dout[k]);
      end
    end
    stray = 1'b0;
    repeat (8) begin
      step();
      for (int k = 0; k < NI; k++) if (ack[k] !== 1'b0) stray = 1'b1;
    end
    n_cmp++;
    if (stray !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_late: got ack after reset, want none");
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 9) == 0) req = ~req;
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 9))
          0: addr = $urandom;
          1: addr = BASE + 32'h3FF0 + 32'($urandom_range(0, 15));
          default: addr = BASE + 32'($urandom_range(0, 160));
        endcase
      end
      prog_we = ($urandom_range(0, 3) == 0);
      prog_addr = ($urandom_range(0, 4) == 0) ? 12'($urandom_range(4088, 4095))
                                              : 12'($urandom_range(0, 47));
      prog_data = $urandom;
      rst = ($urandom_range(0, 199) == 0);
      step();
      for (int k = 0; k < NI; k++) begin
        n_cmp++;
        if (ack[k] !== m_ack[k]) begin
          n_bad++;
          $display("FAIL rand_ack inst%0d cyc%0d: got %0b want %0b", k, cyc, ack[k], m_ack[k]);
        end
        n_cmp++;
        if (dout[k] !== m_data[k]) begin
          n_bad++;
          $display("FAIL rand_data inst%0d cyc%0d: got %h want %h", k, cyc, dout[k], m_data[k]);
        end
      end
    end
    rst = 1'b0;
    prog_we = 1'b0;
    idle(8);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc = 0;
    rst = 1'b1;
    req = 1'b0;
    addr = BASE;
    prog_we = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    for (int k = 0; k < NI; k++) begin
      m_busy[k] = 1'b0;
      m_ack[k]  = 1'b0;
      m_cap[k]  = '0;
      m_due[k]  = 0;
      m_data[k] = '0;
    end
    test_reset();
    test_load();
    test_basic();
    test_wrap();
    test_abort();
    test_redirect();
    test_same_edge();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_bus_responder.md
# fetch_bus_responder

Instruction-bus responder for the fetch stage: the slave end of the `fetch_bus_addr` / `fetch_bus_read_req` → `bus_fetch_data` / `bus_fetch_read_ack` interface. It holds a word-organised instruction memory and services one fetch-group read at a time with fixed, parameterised latency. It aborts cleanly when fetch withdraws or redirects a request. It sits between `fetch` and the simulation/FPGA memory image, replacing the trace-driven bus inputs in the core-level bench.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h8000_0000: byte address of memory word 0.
- `DEPTH_WORDS`, default 4096: memory depth in `INSTRUCTION_WIDTH`-bit words; must be a power of two.
- `LATENCY`, default 1: cycles from request sample to ack; legal range 1..15.

Ports:
- `clk`, in, 1: clock. One clock domain.
- `rst`, in, 1: reset, synchronous, active-high.
- `fetch_bus_addr`, in, `ADDR_WIDTH`: byte address of the first instruction of the group.
- `fetch_bus_read_req`, in, 1: read request, level-held by fetch.
- `bus_fetch_data`, out, `INSTRUCTION_WIDTH*FETCH_WIDTH`: lane i at bits [i*`INSTRUCTION_WIDTH` +: `INSTRUCTION_WIDTH`].
- `bus_fetch_read_ack`, out, 1: data valid, single-cycle pulse.
- `prog_we`, in, 1: memory write enable (image load / self-check).
- `prog_addr`, in, $clog2(DEPTH_WORDS): word index to write.
- `prog_data`, in, `INSTRUCTION_WIDTH`: word to write.

## Operation
- Word index: idx = ((addr − BASE_ADDR) >> 2) mod DEPTH_WORDS. addr[1:0] is ignored.
- Lane i returns mem[(idx + i) mod DEPTH_WORDS]. The group wraps at the top of memory.
- FSM states:
  - IDLE:
    - `fetch_bus_read_req`=1 at an edge → capture addr, load counter = LATENCY−1.
    - If counter = 0 → ACK, else → WAIT.
  - WAIT:
    - Req=0 at an edge → IDLE (abort, no ack).
    - Req=1 with addr ≠ captured → recapture, reload counter = LATENCY−1, stay in WAIT (or go to ACK if LATENCY=1).
    - Otherwise decrement; on counter = 0 → ACK.
  - ACK:
    - ack=1 and data valid for exactly this cycle.
    - Next edge → IDLE unconditionally. Req is not sampled at this edge, because fetch's response to the ack is not yet visible.
- Data is read from memory at the edge entering ACK. A `prog_we` write at that same edge is not visible in this response; it is visible in later ones.
- `prog_we` is accepted in every state and every cycle. The memory is not reset.
- Transfers only on the read port; no write path to fetch, no error response.

## Timing
- Reset values: `bus_fetch_read_ack`=0, `bus_fetch_data`=0, state IDLE, counter 0, captured addr 0.
- Reset asserted mid-transaction → IDLE next edge. No ack is issued for the in-flight request.
- Latency: request sampled at edge t → ack high in the cycle following edge t+LATENCY−1. With LATENCY=1, ack is high in the cycle right after the sampling edge.
- Throughput: one group per LATENCY+1 cycles.
- `bus_fetch_data` holds its last value outside ack cycles. Consumers must qualify with ack.
- All outputs are registered; there is no combinational input→output path.

## Configuration
- `IBUS_RANDOM_STALL_EN` defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle; it is seeded to 16'hACE1 on reset.
  - In WAIT with counter = 0, or in the IDLE→ACK case, the responder stays/enters WAIT while lfsr[0]=1.
  - At most 3 extra stall cycles per transaction.
  - Abort and redirect rules still apply during stalls.
- Not defined: latency is exactly LATENCY. The LFSR is not instantiated.

## Test plan
- Reset then load mem[0..3]=1,2,3,4. LATENCY=1, FETCH_WIDTH=4, req=1 addr=0x8000_0000 at edge t → ack=1 in cycle t+1, lanes {1,2,3,4}; ack=0 the following cycle.
- Wrap test: DEPTH_WORDS=4096, addr=BASE+0x3FFC, mem[4095]=0xAA, mem[0..2]=0x10,0x11,0x12 → lanes {0xAA,0x10,0x11,0x12}.
- Abort: LATENCY=4, req held 2 cycles then dropped → no ack ever. A new req at addr BASE+0x10 two cycles later → ack 4 cycles after its sampling edge with mem[4..7].
- Redirect: LATENCY=3, req addr A, then addr B at the 2nd WAIT edge with req held → single ack, data from B, 3 cycles after the redirect edge.
- Same-edge write: prog_we writes mem[0]=0x55 at the edge entering ACK → ack data lane0 is old value. An immediate re-request returns 0x55.
- Reset mid-WAIT (LATENCY=5, reset at cycle 2) → ack and data 0 next cycle and no ack afterwards. With `IBUS_RANDOM_STALL_EN`, ack latency stays within LATENCY..LATENCY+3 over 1000 random requests.
